// File: rtl/dmem_port_arbiter_if.sv
// Shared data-memory port bundle: MEM-stage requester, external requester and memory side.
// slave = arbiter view, master = environment (pipeline, external agent, memory) view.
interface dmem_port_arbiter_if;
  localparam int unsigned DW = 32;

  logic          core_req;
  logic          core_we;
  logic [DW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          stall_m;

  logic          ext_req;
  logic          ext_we;
  logic [DW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt;
  logic          ext_done;
  logic [DW-1:0] ext_rdata;

  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  mem_rdata,
    output core_rdata, stall_m,
    output ext_gnt, ext_done, ext_rdata,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output mem_rdata,
    input  core_rdata, stall_m,
    input  ext_gnt, ext_done, ext_rdata,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the MEM stage and an external requester, inserting wait states.
// Optional DMEM_ARB_PERF_EN adds saturating stall-cycle and external-grant counters.
module dmem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic               clk,
  input  logic               reset,
  dmem_port_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_ext_cnt
`endif
);
  localparam int unsigned WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned STV_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_CYCLES);
  localparam logic [STV_W-1:0]  STV_LIMIT = STV_W'(STARVE_MAX);
  localparam logic              ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, CORE_BUSY, EXT_BUSY} state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;

  logic idle_c, ext_win_c, core_win_c;
  logic own_core_c, own_ext_c, last_c;
  logic stall_c, gnt_c, done_c;

  // Owner: combinational pick in IDLE, the BUSY state itself afterwards.
  always_comb begin : arb
    idle_c     = (state_q == IDLE);
    ext_win_c  = bus.ext_req && (!bus.core_req || (starve_q == STV_LIMIT));
    core_win_c = bus.core_req && !ext_win_c;
    own_core_c = idle_c ? core_win_c : (state_q == CORE_BUSY);
    own_ext_c  = idle_c ? ext_win_c  : (state_q == EXT_BUSY);
    last_c     = idle_c ? ZERO_WAIT  : (wcnt_q == WCNT_LAST);
    stall_c    = bus.core_req && !(own_core_c && last_c);
    gnt_c      = idle_c && ext_win_c;
    done_c     = own_ext_c && last_c;
  end

  always_comb begin : next_state
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    starve_d = starve_q;
    if (idle_c) begin
      if ((core_win_c || ext_win_c) && !ZERO_WAIT) begin
        state_d = core_win_c ? CORE_BUSY : EXT_BUSY;
        wcnt_d  = WCNT_W'(1);
      end
    end else if (last_c) begin
      state_d = IDLE;
      wcnt_d  = '0;
    end else begin
      wcnt_d = wcnt_q + WCNT_W'(1);
    end
    // Only grants lost while the external side keeps asking count towards starvation.
    if (!bus.ext_req || gnt_c) begin
      starve_d = '0;
    end else if (idle_c && core_win_c && (starve_q != STV_LIMIT)) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin : regs
    if (reset) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      starve_q <= starve_d;
    end
  end

  // Port mux; everything is forced low while reset is held.
  always_comb begin : port_mux
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.core_rdata = '0;
    bus.stall_m    = 1'b0;
    bus.ext_gnt    = 1'b0;
    bus.ext_done   = 1'b0;
    bus.ext_rdata  = '0;
    if (!reset) begin
      if (own_core_c) begin
        bus.mem_we     = bus.core_we && bus.core_req;
        bus.mem_addr   = bus.core_addr;
        bus.mem_wdata  = bus.core_wdata;
        bus.core_rdata = bus.mem_rdata;
      end else if (own_ext_c) begin
        bus.mem_we    = bus.ext_we && bus.ext_req;
        bus.mem_addr  = bus.ext_addr;
        bus.mem_wdata = bus.ext_wdata;
      end
      bus.stall_m  = stall_c;
      bus.ext_gnt  = gnt_c;
      bus.ext_done = done_c;
      if (done_c) begin
        bus.ext_rdata = bus.mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_ext_q, perf_ext_d;

  always_comb begin : perf_next
    perf_stall_d = perf_stall_q;
    perf_ext_d   = perf_ext_q;
    if (stall_c && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (gnt_c && (perf_ext_q != '1)) begin
      perf_ext_d = perf_ext_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin : perf_regs
    if (reset) begin
      perf_stall_q <= '0;
      perf_ext_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_ext_q   <= perf_ext_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_ext_cnt   = perf_ext_q;
`endif
endmodule
